// File: rtl/adc_frame_uart_tx_if.sv
// Signal bundle between the ADC sequencer side and the frame UART transmitter.
// The slave modport is the transmitter; dbg_state exposes its FSM state.
interface adc_frame_uart_tx_if;
   logic       done_in;
   logic [7:0] r1;
   logic [7:0] r2;
   logic [7:0] r3;
   logic [7:0] r4;
   logic       clr_ovr;
   logic       tx;
   logic       busy;
   logic       frame_sent;
   logic       overrun;
   logic [1:0] dbg_state;

   modport master (
      output done_in, r1, r2, r3, r4, clr_ovr,
      input  tx, busy, frame_sent, overrun, dbg_state
   );

   modport slave (
      input  done_in, r1, r2, r3, r4, clr_ovr,
      output tx, busy, frame_sent, overrun, dbg_state
   );
endinterface

// File: rtl/adc_frame_uart_tx.sv
// Captures four ADC channel bytes on a done edge and sends HEADER,ch1..ch4,checksum over UART 8N1.
// Optional macro ADC_FRAME_PARITY_EN switches every byte to 8E1.
module adc_frame_uart_tx #(
   parameter int         CLK_DIV = 434,
   parameter logic [7:0] HEADER  = 8'hA5
) (
   input logic                CLK,
   input logic                RST_N,
   adc_frame_uart_tx_if.slave bus
);

`ifdef ADC_FRAME_PARITY_EN
   localparam int             BITW     = 4;
   localparam logic [BITW-1:0] LAST_BIT = 4'd8;
`else
   localparam int             BITW     = 3;
   localparam logic [BITW-1:0] LAST_BIT = 3'd7;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     baud_q, baud_d;
   logic [BITW-1:0] bit_q, bit_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      b1_q, b1_d, b2_q, b2_d, b3_q, b3_d, b4_q, b4_d;
   logic            done_d_q;
   logic            busy_q, busy_d;
   logic            frame_sent_q, frame_sent_d;
   logic            overrun_q, overrun_d;
   logic            tx_q, tx_d;

   logic            trig;
   logic            blocked;
   logic            baud_tick;
   logic [7:0]      ck;
   logic [7:0]      cur_byte;
   logic            data_bit;

   assign trig      = bus.done_in & ~done_d_q;
   // The frame_sent cycle still counts as busy so a trigger there is dropped.
   assign blocked   = busy_q | frame_sent_q;
   assign baud_tick = (baud_q == 16'(CLK_DIV - 1));
   // 8-bit adds wrap, which is exactly the mod-256 checksum.
   assign ck        = b1_q + b2_q + b3_q + b4_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         idx_q        <= '0;
         b1_q         <= '0;
         b2_q         <= '0;
         b3_q         <= '0;
         b4_q         <= '0;
         done_d_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_sent_q <= 1'b0;
         overrun_q    <= 1'b0;
         tx_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         idx_q        <= idx_d;
         b1_q         <= b1_d;
         b2_q         <= b2_d;
         b3_q         <= b3_d;
         b4_q         <= b4_d;
         done_d_q     <= bus.done_in;
         busy_q       <= busy_d;
         frame_sent_q <= frame_sent_d;
         overrun_q    <= overrun_d;
         tx_q         <= tx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_tick ? 16'd0 : 16'(baud_q + 16'd1);
      bit_d        = bit_q;
      idx_d        = idx_q;
      b1_d         = b1_q;
      b2_d         = b2_q;
      b3_d         = b3_q;
      b4_d         = b4_q;
      busy_d       = busy_q;
      frame_sent_d = 1'b0;

      if (trig && blocked)   overrun_d = 1'b1;
      else if (bus.clr_ovr)  overrun_d = 1'b0;
      else                   overrun_d = overrun_q;

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (trig && !blocked) begin
               b1_d    = bus.r1;
               b2_d    = bus.r2;
               b3_d    = bus.r3;
               b4_d    = bus.r4;
               idx_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_tick) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (bit_q == LAST_BIT) state_d = S_STOP;
               else                   bit_d   = BITW'(bit_q + 1'b1);
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               bit_d = '0;
               if (idx_q != 3'd5) begin
                  idx_d   = 3'(idx_q + 3'd1);
                  state_d = S_START;
               end else begin
                  frame_sent_d = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (idx_q)
         3'd0:    cur_byte = HEADER;
         3'd1:    cur_byte = b1_q;
         3'd2:    cur_byte = b2_q;
         3'd3:    cur_byte = b3_q;
         3'd4:    cur_byte = b4_q;
         default: cur_byte = ck;
      endcase

`ifdef ADC_FRAME_PARITY_EN
      // Bit slot 8 carries even parity over the data byte.
      data_bit = (bit_q == 4'd8) ? ^cur_byte : cur_byte[bit_q[2:0]];
`else
      data_bit = cur_byte[bit_q];
`endif

      // tx is registered, so the line lags the state by one cycle.
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = data_bit;
         default: tx_d = 1'b1;
      endcase
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.frame_sent = frame_sent_q;
   assign bus.overrun    = overrun_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: doc/adc_frame_uart_tx.md
Name: adc_frame_uart_tx

Overview:
- Downstream consumer of the 4-channel ADC sequencer.
- Captures the four channel bytes on each new done pulse and packs them into a 6-byte frame: header, ch1..ch4, checksum.
- Transmits the frame LSB-first over a UART TX line (8N1) to the host.
- Provides busy/overrun status so the system can detect dropped conversions.

Parameters:
- CLK_DIV, 434, CLK cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RST_N  input  1  asynchronous active-low reset.
- done_in  input  1  conversion-set-complete flag from the ADC sequencer; high for >=1 cycle (nominally 2), level not pulse.
- r1  input  8  channel 0 sample.
- r2  input  8  channel 1 sample.
- r3  input  8  channel 2 sample.
- r4  input  8  channel 3 sample.
- clr_ovr  input  1  synchronous clear of overrun.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a frame is in flight.
- frame_sent  output  1  one-cycle pulse after the last stop bit of a frame.
- overrun  output  1  sticky: a done edge arrived while busy.

Behaviour:
- Reset (async assert, sync-free release): tx=1, busy=0, frame_sent=0, overrun=0, FSM=IDLE, all counters and capture registers 0. Asserting reset mid-frame aborts the frame; tx goes to 1 immediately.
- Edge detect:
  - done_d registered from done_in.
  - Trigger = done_in & ~done_d. A held-high done gives exactly one trigger.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on trigger at posedge k, capture r1..r4 into b1..b4.
  - Checksum ck = (b1+b2+b3+b4) mod 256, computed from the captured values in a 10-bit sum, low 8 bits kept.
  - Load byte index=0 (HEADER), set busy=1, go to START.
  - tx falls at posedge k+1: one-cycle latency from the trigger edge to the start bit.
- START: tx=0 for CLK_DIV cycles, then DATA.
- DATA: 8 bits, LSB first, each held CLK_DIV cycles; bit counter 0..7; then STOP.
- STOP: tx=1 for CLK_DIV cycles.
  - If index<5: index+1 and go to START, giving back-to-back bytes with no idle gap.
  - Else: frame_sent=1 for one cycle, busy=0, go to IDLE.
- Byte order by index: 0=HEADER, 1=b1, 2=b2, 3=b3, 4=b4, 5=ck.
- Frame length: 60*CLK_DIV cycles from the start-bit edge to the end of the last stop bit.
- Baud counter: counts 0..CLK_DIV-1 and wraps. It is reloaded to 0 on every state/bit change, with no drift between bits.
- Overrun: a trigger while busy=1 sets overrun=1. The in-flight frame is unaffected and the new sample set is dropped (not queued).
- clr_ovr=1 clears overrun. If clr_ovr and a new overrun occur in the same cycle, set wins (overrun=1).
- A trigger in the same cycle frame_sent pulses (FSM returning to IDLE) counts as busy: overrun is set and the set is dropped.
- r1..r4 may change freely after capture; the transmitted data never reflects post-capture changes.

Optional Feature:
- Macro: ADC_FRAME_PARITY_EN.
- Defined: each byte is sent 8E1, with an even-parity bit after bit 7 held CLK_DIV cycles. Frame length becomes 66*CLK_DIV cycles.
- Not defined: plain 8N1 as above; no parity logic is synthesised.

Test Plan:
- CLK_DIV=4, r1=8'h01 r2=8'h02 r3=8'h03 r4=8'h04, done_in high 2 cycles -> tx decodes A5 01 02 03 04 0A; busy high 240 cycles; one frame_sent pulse; overrun=0.
- r1..r4=8'hFF, done_in pulse -> checksum byte 8'hFC (1020 mod 256); r1..r4 changed to 8'h00 mid-frame -> still sends FF FF FF FF FC.
- Second done_in rising edge 50 cycles into a frame -> first frame completes unaltered, no second frame, overrun=1. Then clr_ovr pulse -> overrun=0.
- done_in held high 500 cycles -> exactly one frame, overrun stays 0.
- RST_N low at cycle 100 of a frame -> tx=1 and busy=0 immediately, no frame_sent. A new done_in after release gives a complete, correct frame.
- ADC_FRAME_PARITY_EN defined, r1=8'h07 (others 0) -> parity bits: A5->0, 07->1, 00->0, ck 07->1; busy 264 cycles.
